// File: rtl/reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reset_sequencer: releases NUM_STAGES reset domains in order, each        |
// | gated by its init-done ack. Macro RSTSEQ_TIMEOUT_EN adds ack timeout.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module reset_sequencer #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DLY   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_STAGES-1:0]         stage_ack_i,
  input  logic                          soft_rst_req_i,
  output logic [NUM_STAGES-1:0]         stage_rst_o,
  output logic                          all_ready_o,
  output logic                          busy_o,
  output logic [$clog2(NUM_STAGES)-1:0] cur_stage_o,
  output logic                          timeout_o
);

`ifdef RSTSEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int SW      = $clog2(NUM_STAGES);
  localparam int CNT_MAX = TO_EN ? ((STAGE_DLY > TIMEOUT_CYC) ? STAGE_DLY : TIMEOUT_CYC)
                                 : STAGE_DLY;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0]      LAST_DLY = CNT_W'(STAGE_DLY - 1);
  localparam logic [SW-1:0]         LAST_STG = SW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ONE_HOT  = NUM_STAGES'(1);
`ifdef RSTSEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0]      LAST_TO  = CNT_W'(TIMEOUT_CYC - 1);
`endif

  typedef enum logic [2:0] {
    ASSERT   = 3'd0,
    DELAY    = 3'd1,
    WAIT_ACK = 3'd2,
    DONE     = 3'd3,
    FAULT    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]           cur_q, cur_d;
  logic [NUM_STAGES-1:0]   srst_q, srst_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      cur_q   <= '0;
      srst_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      srst_q  <= srst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    srst_d  = srst_q;
    case (state_q)
      ASSERT: begin
        srst_d = '1;
        if (cnt_q == LAST_DLY) begin
          srst_d[0] = 1'b0;
          cur_d     = '0;
          cnt_d     = '0;
          state_d   = WAIT_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        // Only the awaited stage's ack counts; an ack beats a timeout on the same edge.
        if (stage_ack_i[cur_q]) begin
          cnt_d   = '0;
          state_d = (cur_q == LAST_STG) ? DONE : DELAY;
        end
`ifdef RSTSEQ_TIMEOUT_EN
        else if (cnt_q == LAST_TO) begin
          srst_d  = '1;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DELAY: begin
        if (cnt_q == LAST_DLY) begin
          cur_d   = cur_q + SW'(1);
          srst_d  = srst_q & ~(ONE_HOT << cur_d);
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE, FAULT: begin
        srst_d = (state_q == DONE) ? '0 : '1;
        if (soft_rst_req_i) begin
          srst_d  = '1;
          cur_d   = '0;
          cnt_d   = '0;
          state_d = ASSERT;
        end
      end
      default: begin
        srst_d  = '1;
        cur_d   = '0;
        cnt_d   = '0;
        state_d = ASSERT;
      end
    endcase
  end

  assign stage_rst_o = srst_q;
  assign cur_stage_o = cur_q;
  assign all_ready_o = (state_q == DONE);
  assign busy_o      = (state_q == ASSERT) || (state_q == DELAY) || (state_q == WAIT_ACK);
`ifdef RSTSEQ_TIMEOUT_EN
  assign timeout_o   = (state_q == FAULT);
`else
  assign timeout_o   = 1'b0;
`endif

endmodule
`default_nettype wire
